reg_mem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream register-memory port (req/ack, address, write/read enable, write/read data) among REQ_NUM native requesters, all in one clock domain. It sits between several snapshot-side memory masters and a single memory or memory bridge. It serialises accesses, holds one transaction open until the memory acknowledges, and returns the acknowledge and read data to the granted requester only.

---
 rtl/reg_mem_rr_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_reg_mem_rr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_mem_rr_arbiter
// Purpose  : Round-robin arbiter sharing one register-memory port (req/ack,
//            address, write/read enable, write/read data) among REQ_NUM
//            requesters. One transaction is held open until the memory
//            acknowledges; the acknowledge and read data go back to the
//            granted requester only. Single clock domain.
// Ports    : clk, soft_rst (sync, active high)
//            requester side : req_vld, addr, wr_en, rd_en, wr_data (packed,
//                             requester i uses slice i), ack_vld (one-hot
//                             pulse), rd_data, err_vld, grant_id
//            memory side    : mem_req_vld, mem_addr, mem_wr_en, mem_rd_en,
//                             mem_wr_data, mem_ack_vld, mem_rd_data
// Options  : REG_MEM_ARB_TIMEOUT_EN enables a watchdog that completes an
//            access after TIMEOUT_CYCLES cycles in REQ with err_vld and
//            rd_data = TIMEOUT_DATA. Without it err_vld is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module reg_mem_rr_arbiter #(
  parameter int                        REQ_NUM        = 2,
  parameter int                        MEM_ADDR_WIDTH = 5,
  parameter int                        MEM_DATA_WIDTH = 64,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [MEM_DATA_WIDTH-1:0] TIMEOUT_DATA   = '1
) (
  input  logic                                clk,
  input  logic                                soft_rst,
  input  logic [REQ_NUM-1:0]                  req_vld,
  input  logic [REQ_NUM*MEM_ADDR_WIDTH-1:0]   addr,
  input  logic [REQ_NUM-1:0]                  wr_en,
  input  logic [REQ_NUM-1:0]                  rd_en,
  input  logic [REQ_NUM*MEM_DATA_WIDTH-1:0]   wr_data,
  output logic [REQ_NUM-1:0]                  ack_vld,
  output logic [MEM_DATA_WIDTH-1:0]           rd_data,
  output logic                                err_vld,
  output logic [$clog2(REQ_NUM)-1:0]          grant_id,
  output logic                                mem_req_vld,
  input  logic                                mem_ack_vld,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_addr,
  output logic                                mem_wr_en,
  output logic                                mem_rd_en,
  output logic [MEM_DATA_WIDTH-1:0]           mem_wr_data,
  input  logic [MEM_DATA_WIDTH-1:0]           mem_rd_data
);

  localparam int GW = $clog2(REQ_NUM);
  localparam logic [GW-1:0] LAST_ID = GW'(REQ_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               last_grant_q, last_grant_d;
  logic                        mem_req_vld_q, mem_req_vld_d;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                        mem_wr_en_q, mem_wr_en_d;
  logic                        mem_rd_en_q, mem_rd_en_d;
  logic [MEM_DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [MEM_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [REQ_NUM-1:0]          ack_vld_q, ack_vld_d;

  // Per-requester views of the packed field buses.
  logic [MEM_ADDR_WIDTH-1:0]   addr_arr    [REQ_NUM];
  logic [MEM_DATA_WIDTH-1:0]   wr_data_arr [REQ_NUM];

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
    assign addr_arr[gi]    = addr[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    assign wr_data_arr[gi] = wr_data[gi*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
  end

  // Round-robin winner: first active request starting one past the last
  // grant, wrapping modulo REQ_NUM.
  logic [GW-1:0] win_id;
  logic          win_found;
  logic [GW-1:0] cand;

  always_comb begin
    win_id    = last_grant_q;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = GW'((int'(last_grant_q) + k) % REQ_NUM);
      if (!win_found && req_vld[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

`ifdef REG_MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_vld_q, err_vld_d;
`else
  // Watchdog parameters have no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_DATA, 16'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_req_vld_d = mem_req_vld_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_data_d     = rd_data_q;
    ack_vld_d     = '0;
`ifdef REG_MEM_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_vld_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          last_grant_d  = win_id;
          mem_req_vld_d = 1'b1;
          mem_addr_d    = addr_arr[win_id];
          mem_wr_en_d   = wr_en[win_id];
          mem_rd_en_d   = rd_en[win_id];
          mem_wr_data_d = wr_data_arr[win_id];
          state_d       = REQ;
`ifdef REG_MEM_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack_vld) begin
          mem_req_vld_d           = 1'b0;
          mem_wr_en_d             = 1'b0;
          mem_rd_en_d             = 1'b0;
          rd_data_d               = mem_rd_data;
          ack_vld_d[last_grant_q] = 1'b1;
          state_d                 = RESP;
        end
`ifdef REG_MEM_ARB_TIMEOUT_EN
        // The last REQ cycle is the TIMEOUT_CYCLES-th; an ack in that same
        // cycle takes priority over the watchdog.
        else if (cnt_q == TO_LAST) begin
          mem_req_vld_d           = 1'b0;
          mem_wr_en_d             = 1'b0;
          mem_rd_en_d             = 1'b0;
          rd_data_d               = TIMEOUT_DATA;
          ack_vld_d[last_grant_q] = 1'b1;
          err_vld_d               = 1'b1;
          state_d                 = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        // Dead cycle so the requester can drop req_vld before re-arbitration.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q       <= IDLE;
      last_grant_q  <= LAST_ID;
      mem_req_vld_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
      ack_vld_q     <= '0;
`ifdef REG_MEM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err_vld_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_req_vld_q <= mem_req_vld_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_data_q     <= rd_data_d;
      ack_vld_q     <= ack_vld_d;
`ifdef REG_MEM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_vld_q     <= err_vld_d;
`endif
    end
  end

  assign ack_vld     = ack_vld_q;
  assign rd_data     = rd_data_q;
  assign grant_id    = last_grant_q;
  assign mem_req_vld = mem_req_vld_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_data = mem_wr_data_q;
`ifdef REG_MEM_ARB_TIMEOUT_EN
  assign err_vld     = err_vld_q;
`else
  assign err_vld     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_mem_rr_arbiter
// Purpose  : Self-checking bench for reg_mem_rr_arbiter with three
//            requesters. Directed steps plus randomized request traffic
//            compared against a queue-based round-robin reference model.
//            Watchdog steps run when REG_MEM_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_mem_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int GW = $clog2(N);
`ifdef REG_MEM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic            clk = 1'b0;
  logic            soft_rst;
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    wr_en;
  logic [N-1:0]    rd_en;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    ack_vld;
  logic [DW-1:0]   rd_data;
  logic            err_vld;
  logic [GW-1:0]   grant_id;
  logic            mem_req_vld;
  logic            mem_ack_vld;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_wr_data;
  logic [DW-1:0]   mem_rd_data;

  reg_mem_rr_arbiter #(
    .REQ_NUM        (N),
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   ({DW{1'b1}})
  ) dut (
    .clk         (clk),
    .soft_rst    (soft_rst),
    .req_vld     (req_vld),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_data     (wr_data),
    .ack_vld     (ack_vld),
    .rd_data     (rd_data),
    .err_vld     (err_vld),
    .grant_id    (grant_id),
    .mem_req_vld (mem_req_vld),
    .mem_ack_vld (mem_ack_vld),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise = -100;
  bit prev_zero = 1'b0;

  // Reference model: priority order queue (head = highest priority) and
  // per-requester pending transaction.
  int            order[$];
  bit            pend  [N];
  logic [AW-1:0] m_addr[N];
  logic          m_wr  [N];
  logic          m_rd  [N];
  logic [DW-1:0] m_wd  [N];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void reset_model();
    order = {};
    for (int i = 0; i < N; i++) begin
      order.push_back(i);
      pend[i] = 1'b0;
    end
  endfunction

  function automatic int pick();
    foreach (order[j]) if (pend[order[j]]) return order[j];
    return -1;
  endfunction

  // After a grant the winner becomes lowest priority: rotate it to the tail.
  function automatic void grant(input int w);
    int h;
    for (int j = 0; j < N; j++) begin
      h = order.pop_front();
      order.push_back(h);
      if (h == w) break;
    end
  endfunction

  task automatic new_request(input int i);
    pend[i]   = 1'b1;
    m_addr[i] = AW'($urandom);
    m_wr[i]   = 1'($urandom_range(0, 1));
    m_rd[i]   = 1'($urandom_range(0, 1));
    m_wd[i]   = {$urandom, $urandom};
  endtask

  // Idle requesters present random junk on their fields.
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_vld[i]             = pend[i];
      addr[i*AW +: AW]       = pend[i] ? m_addr[i] : AW'($urandom);
      wr_en[i]               = pend[i] ? m_wr[i] : 1'($urandom);
      rd_en[i]               = pend[i] ? m_rd[i] : 1'($urandom);
      wr_data[i*DW +: DW]    = pend[i] ? m_wd[i] : {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    soft_rst    = 1'b1;
    mem_ack_vld = 1'b0;
    mem_rd_data = '0;
    reset_model();
    drive_reqs();
    step();
    step();
    soft_rst  = 1'b0;
    prev_zero = 1'b0;
  endtask

  // One full transaction: grant, w wait cycles, ack, RESP, IDLE.
  // Returns the grant_id observed from the DUT at grant time.
  task automatic do_round(input int w, input bit drop_mid, input bit rnd, output int won);
    int            win;
    logic [N-1:0]  oh;
    logic [DW-1:0] d;
    win = pick();
    if (win < 0) begin
      new_request($urandom_range(0, N-1));
      drive_reqs();
      win = pick();
    end
    step();
    won = int'(grant_id);
    check("grant_req",   64'(mem_req_vld), 64'd1);
    check("grant_id",    64'(grant_id),    64'(win));
    check("grant_addr",  64'(mem_addr),    64'(m_addr[win]));
    check("grant_wr_en", 64'(mem_wr_en),   64'(m_wr[win]));
    check("grant_rd_en", 64'(mem_rd_en),   64'(m_rd[win]));
    check("grant_wdata", mem_wr_data,      m_wd[win]);
    if (prev_zero && w == 0) check("rise_gap", 64'(cyc - last_rise), 64'd3);
    last_rise = cyc;
    prev_zero = (w == 0);
    for (int j = 0; j < w; j++) begin
      if (rnd) for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) new_request(i);
      drive_reqs();
      if (drop_mid) req_vld[win] = 1'b0;
      step();
      check("wait_req",  64'(mem_req_vld), 64'd1);
      check("wait_ack",  64'(ack_vld),     64'd0);
      check("wait_addr", 64'(mem_addr),    64'(m_addr[win]));
    end
    d           = {$urandom, $urandom};
    mem_ack_vld = 1'b1;
    mem_rd_data = d;
    step();
    mem_ack_vld = 1'b0;
    mem_rd_data = {$urandom, $urandom};
    oh      = '0;
    oh[win] = 1'b1;
    check("ack_onehot", 64'(ack_vld),     64'(oh));
    check("ack_rdata",  rd_data,          d);
    check("ack_req_lo", 64'(mem_req_vld), 64'd0);
    check("ack_en_lo",  64'({mem_wr_en, mem_rd_en}), 64'd0);
    check("ack_err",    64'(err_vld),     64'd0);
    pend[win] = 1'b0;
    grant(win);
    drive_reqs();
    if (rnd) mem_ack_vld = 1'($urandom_range(0, 1));   // stray ack in RESP
    step();
    mem_ack_vld = 1'b0;
    check("resp_ack",   64'(ack_vld), 64'd0);
    check("hold_rdata", rd_data,      d);
    if (rnd) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_request(i);
    end else begin
      new_request(win);
    end
    drive_reqs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int won;
    int exp_seq[4];
    exp_seq = '{0, 1, 0, 1};
    req_vld = '0; addr = '0; wr_en = '0; rd_en = '0; wr_data = '0;

    // Reset state
    do_reset();
    check("rst_req",    64'(mem_req_vld), 64'd0);
    check("rst_ack",    64'(ack_vld),     64'd0);
    check("rst_err",    64'(err_vld),     64'd0);
    check("rst_grant",  64'(grant_id),    64'(N-1));
    check("rst_rdata",  rd_data,          64'd0);
    check("rst_addr",   64'(mem_addr),    64'd0);
    check("rst_wdata",  mem_wr_data,      64'd0);
    check("rst_en",     64'({mem_wr_en, mem_rd_en}), 64'd0);

    // Single read from requester 0, memory acks at cycle 3
    req_vld = 3'b001; addr = '0; addr[4:0] = 5'h03; rd_en = 3'b001; wr_en = '0;
    step();
    check("t1_req_c1", 64'(mem_req_vld), 64'd1);
    check("t1_addr",   64'(mem_addr),    64'h03);
    check("t1_rd_en",  64'(mem_rd_en),   64'd1);
    check("t1_grant",  64'(grant_id),    64'd0);
    step();
    check("t1_req_c2", 64'(mem_req_vld), 64'd1);
    step();
    check("t1_req_c3", 64'(mem_req_vld), 64'd1);
    check("t1_ack_c3", 64'(ack_vld),     64'd0);
    mem_ack_vld = 1'b1; mem_rd_data = 64'h1234;
    step();
    mem_ack_vld = 1'b0; mem_rd_data = 64'hdead;
    req_vld = '0;
    check("t1_ack_c4",  64'(ack_vld),     64'b001);
    check("t1_rdata",   rd_data,          64'h1234);
    check("t1_req_c4",  64'(mem_req_vld), 64'd0);
    step();
    check("t1_ack_c5",  64'(ack_vld),     64'd0);
    check("t1_hold",    rd_data,          64'h1234);

    // Requesters 0 and 1 continuously requesting: grants 0,1,0,1
    do_reset();
    new_request(0);
    new_request(1);
    drive_reqs();
    for (int r = 0; r < 4; r++) begin
      do_round($urandom_range(0, 3), 1'b0, 1'b0, won);
      check("rr_seq", 64'(won), 64'(exp_seq[r]));
    end

    // Zero-wait memory, back-to-back: grants 3 cycles apart
    do_reset();
    for (int i = 0; i < N; i++) new_request(i);
    drive_reqs();
    for (int r = 0; r < 6; r++) do_round(0, 1'b0, 1'b1, won);

    // Randomized traffic, random wait, occasional mid-REQ req_vld drop
    for (int r = 0; r < 40; r++)
      do_round($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b1, won);

    // Spurious ack in IDLE, then reset in the middle of REQ
    do_reset();
    mem_ack_vld = 1'b1;
    step();
    mem_ack_vld = 1'b0;
    check("spur_ack",  64'(ack_vld),     64'd0);
    check("spur_req",  64'(mem_req_vld), 64'd0);
    new_request(0);
    drive_reqs();
    step();
    check("mr_req",    64'(mem_req_vld), 64'd1);
    check("mr_grant",  64'(grant_id),    64'd0);
    step();
    soft_rst = 1'b1;
    step();
    check("mr_req_lo", 64'(mem_req_vld), 64'd0);
    check("mr_ack",    64'(ack_vld),     64'd0);
    check("mr_grant_rst", 64'(grant_id), 64'(N-1));
    soft_rst = 1'b0;
    pend[0]  = 1'b0;
    drive_reqs();
    mem_ack_vld = 1'b1;
    step();
    mem_ack_vld = 1'b0;
    step();
    check("mr_no_ack", 64'(ack_vld),     64'd0);

`ifdef REG_MEM_ARB_TIMEOUT_EN
    // Watchdog expiry: ack + err at cycle 5 after the grant is sampled
    do_reset();
    new_request(0);
    drive_reqs();
    step();
    check("to_req", 64'(mem_req_vld), 64'd1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("to_wait_ack", 64'(ack_vld), 64'd0);
      check("to_wait_err", 64'(err_vld), 64'd0);
    end
    step();
    check("to_ack",    64'(ack_vld),     64'b001);
    check("to_err",    64'(err_vld),     64'd1);
    check("to_rdata",  rd_data,          {DW{1'b1}});
    check("to_req_lo", 64'(mem_req_vld), 64'd0);
    pend[0] = 1'b0;
    drive_reqs();
    step();
    check("to_err_lo", 64'(err_vld), 64'd0);

    // Ack on the limit cycle wins over the watchdog
    new_request(1);
    drive_reqs();
    step();
    check("tl_grant", 64'(grant_id), 64'd1);
    step();
    step();
    step();
    mem_ack_vld = 1'b1; mem_rd_data = 64'h0bad_cafe_5555_aaaa;
    step();
    mem_ack_vld = 1'b0;
    check("tl_ack",   64'(ack_vld), 64'b010);
    check("tl_err",   64'(err_vld), 64'd0);
    check("tl_rdata", rd_data,      64'h0bad_cafe_5555_aaaa);
    pend[1] = 1'b0;
    drive_reqs();
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
